seg_scan_ctrl: RTL
==================

Name: seg_scan_ctrl

Overview:
- Multiplexed scan controller for a common-anode, multi-digit seven-segment display.
- Takes a packed hex value plus decimal points over a valid/ready handshake and buffers one pending update, applied only at a frame boundary so no frame tears.
- Time-multiplexes the digits and emits one 4-bit nibble per slot to the downstream hex-to-segment decoder.
- Drives the active-low digit anodes and the decimal point, with leading-zero blanking and an anti-ghosting guard interval.

Parameters:
- DIGITS, 4, number of digits (2..8); digit 0 is least significant.
- DIV, 50000, clk cycles per digit slot (>= 2).
- GUARD, 2, clk cycles at the start of each slot with all anodes off (0 <= GUARD < DIV).
- LZ_BLANK, 1, 1 enables leading-zero blanking.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- data_in  in  4*DIGITS  packed hex digits; digit i is data_in[4i+3:4i].
- dp_in  in  DIGITS  decimal point per digit, 1 = lit.
- data_in_valid  in  1  update offered.
- data_in_ready  out  1  pending buffer empty.
- display_en  in  1  0 = all anodes off; counters keep running.
- digit_nibble  out  4  current digit value to the decoder.
- digit_blank  out  1  1 = decoder output must be forced dark.
- an_n  out  DIGITS  active-low one-hot anode select.
- dp_n  out  1  active-low decimal point.

Behaviour:
- Reset: asynchronous, takes effect immediately on rst high. Clears slot counter cnt, digit index idx, active value/dp, pending buffer and pending flag. Outputs during reset:
  - an_n all ones.
  - digit_nibble 0.
  - digit_blank 1.
  - dp_n 1.
  - data_in_ready 1.
- Reset mid-frame or mid-handshake discards any pending update. The first slot after reset release is digit 0, full length.
- Slot counter:
  - cnt counts 0..DIV-1, width clog2(DIV).
  - tick = (cnt == DIV-1).
  - On tick, cnt returns to 0 and idx advances. idx wraps from DIGITS-1 to 0.
- Frame boundary: tick with idx == DIGITS-1. At that edge, if the pending flag is set:
  - active value and dp take the pending value and dp;
  - the pending flag clears.
- Handshake:
  - data_in_ready = !pending_flag (combinational from the flag).
  - Accept occurs when valid && ready: data_in/dp_in are captured into pending and the flag is set.
  - With the flag set, ready is low and data_in is ignored.
  - An accept on the same edge as a frame boundary loads pending with the new data; it is applied at the following boundary.
  - A boundary apply and an accept cannot collide, because ready is low whenever pending is full.
- Outputs are registered with one clk of latency from (cnt, idx, active, display_en):
  - digit_nibble = active digit idx.
  - an_n = ~(1<<idx) when display_en && cnt >= GUARD; all ones otherwise.
  - dp_n = ~active_dp[idx].
- Leading-zero blanking (LZ_BLANK=1):
  - digit i > 0 is blanked when digit i and every higher digit equal 0;
  - digit 0 is never blanked;
  - dp is unaffected by blanking;
  - a blanked digit still drives its anode, with digit_blank = 1.
- LZ_BLANK=0: digit_blank = 0 except during reset.
- display_en low: an_n all ones and dp_n 1; nibble, handshake and frame timing are unaffected.
- Single clock domain; data_in and display_en are synchronous to clk.

Decomposition:
- Shared package holds:
  - SEG_DIGIT_W = 4;
  - the anode-off constant (all ones);
  - function onehot_n(idx, DIGITS);
  - function lz_mask(value), which returns per-digit blank flags.
- One natural sub-module, seg_scan_tick: the DIV slot counter, producing tick and cnt for the guard comparison.
- The scan FSM and handshake stay in the top module.
- digit_nibble/digit_blank feed the existing hex-to-segment decoder, which ORs blank into its active-low outputs.

Test Plan:
All scenarios use DIGITS=4, DIV=4, GUARD=1.
- Reset value check: assert rst mid-slot -> an_n=4'b1111, digit_blank=1, dp_n=1, data_in_ready=1 immediately; after release, digit 0 is selected from the first slot.
- Scan order and guard: load 16'h1234 -> after frame boundary:
  - an_n sequence 1110,1101,1011,0111 repeating;
  - each slot 4 clks, with the first clk of each slot at 1111;
  - nibbles 4,3,2,1.
- Frame-boundary apply: send 16'hABCD mid-frame -> ready drops next clk; active is unchanged until idx 3 tick; the next frame shows D,C,B,A; ready returns to 1.
- Backpressure: a second valid (16'h0F0F) while pending -> not accepted (ready=0), value held; the bench drives it again after ready rises and it appears one frame later.
- Leading-zero blanking: 16'h0005, dp_in=4'b0100:
  - digits 3,2,1 have digit_blank=1;
  - digit 0 nibble 5, blank 0;
  - dp_n=0 only in the digit 2 slot.
  With value 0 -> only digit 0 unblanked.
- display_en low for one frame -> an_n stays 1111 and dp_n=1, while nibbles still cycle; re-enable restores normal scanning.

Source files
------------

// File: rtl/seg_scan_ctrl_pkg.sv
// Shared constants, types and helpers for the multiplexed seven-segment scan controller.
// Helpers work on an 8-digit maximum; callers truncate to their own DIGITS width.
package seg_scan_ctrl_pkg;

    localparam int SEG_DIGIT_W = 4;
    localparam int MAX_DIGITS  = 8;
    localparam logic [MAX_DIGITS-1:0] AN_OFF = '1;

    typedef enum logic {
        PEND_EMPTY = 1'b0,
        PEND_FULL  = 1'b1
    } pend_state_t;

    // Active-low one-hot anode pattern; indices outside the digit count select nothing.
    function automatic logic [MAX_DIGITS-1:0] onehot_n(input int unsigned idx,
                                                       input int unsigned digits);
        logic [MAX_DIGITS-1:0] r;
        r = AN_OFF;
        for (int i = 0; i < MAX_DIGITS; i++) begin
            if ((i == int'(idx)) && (i < int'(digits))) begin
                r[i] = 1'b0;
            end
        end
        return r;
    endfunction

    // Per-digit blank flags: digit i > 0 is blanked when it and all higher digits are zero.
    function automatic logic [MAX_DIGITS-1:0] lz_mask(input logic [SEG_DIGIT_W*MAX_DIGITS-1:0] value);
        logic [MAX_DIGITS-1:0] mask;
        logic                  all_zero;
        mask     = '0;
        all_zero = 1'b1;
        for (int i = MAX_DIGITS - 1; i >= 1; i--) begin
            all_zero = all_zero && (value[i*SEG_DIGIT_W +: SEG_DIGIT_W] == '0);
            mask[i]  = all_zero;
        end
        return mask;
    endfunction

endpackage

// File: rtl/seg_scan_ctrl_tick.sv
// Digit-slot timebase: counts 0..DIV-1 and flags the last cycle of each slot.
module seg_scan_tick #(
    parameter int DIV = 50000,
    parameter int CW  = (DIV > 1) ? $clog2(DIV) : 1
) (
    input  logic          clk,
    input  logic          rst,
    output logic [CW-1:0] cnt,
    output logic          tick
);

    assign tick = (cnt == CW'(DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Seven-segment scan controller: one-deep update buffer applied at frame boundaries,
// digit multiplexing with guard interval, leading-zero blanking and registered outputs.
module seg_scan_ctrl
    import seg_scan_ctrl_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int DIV      = 50000,
    parameter int GUARD    = 2,
    parameter int LZ_BLANK = 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [SEG_DIGIT_W*DIGITS-1:0]   data_in,
    input  logic [DIGITS-1:0]               dp_in,
    input  logic                            data_in_valid,
    output logic                            data_in_ready,
    input  logic                            display_en,
    output logic [SEG_DIGIT_W-1:0]          digit_nibble,
    output logic                            digit_blank,
    output logic [DIGITS-1:0]               an_n,
    output logic                            dp_n
);

    localparam int IW = $clog2(DIGITS);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int VW = SEG_DIGIT_W * DIGITS;

    logic [CW-1:0] cnt;
    logic          tick;
    logic          frame_end;
    logic          accept;
    logic          apply;

    pend_state_t   state_reg, state_next;
    logic [VW-1:0]     pending_reg, active_reg;
    logic [DIGITS-1:0] pending_dp_reg, active_dp_reg;
    logic [IW-1:0]     idx_reg;

    seg_scan_tick #(.DIV(DIV), .CW(CW)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .cnt  (cnt),
        .tick (tick)
    );

    assign frame_end     = tick && (idx_reg == IW'(DIGITS - 1));
    assign data_in_ready = (state_reg == PEND_EMPTY);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= PEND_EMPTY;
        end else begin
            state_reg <= state_next;
        end
    end

    // Accept and apply are mutually exclusive: a full buffer never accepts.
    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        apply      = 1'b0;
        case (state_reg)
            PEND_EMPTY: begin
                if (data_in_valid) begin
                    accept     = 1'b1;
                    state_next = PEND_FULL;
                end
            end
            PEND_FULL: begin
                if (frame_end) begin
                    apply      = 1'b1;
                    state_next = PEND_EMPTY;
                end
            end
            default: state_next = PEND_EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_reg    <= '0;
            pending_dp_reg <= '0;
            active_reg     <= '0;
            active_dp_reg  <= '0;
            idx_reg        <= '0;
        end else begin
            if (accept) begin
                pending_reg    <= data_in;
                pending_dp_reg <= dp_in;
            end
            if (apply) begin
                active_reg    <= pending_reg;
                active_dp_reg <= pending_dp_reg;
            end
            if (tick) begin
                idx_reg <= (idx_reg == IW'(DIGITS - 1)) ? '0 : idx_reg + 1'b1;
            end
        end
    end

    logic [DIGITS-1:0]      blank_mask;
    logic [DIGITS-1:0]      an_sel;
    logic                   guard_done;
    logic [SEG_DIGIT_W-1:0] nibble_next;
    logic                   blank_next;
    logic [DIGITS-1:0]      an_next;
    logic                   dp_next;

    always_comb begin
        blank_mask  = DIGITS'(lz_mask((SEG_DIGIT_W*MAX_DIGITS)'(active_reg)));
        an_sel      = DIGITS'(onehot_n(32'(idx_reg), DIGITS));
        guard_done  = (int'(cnt) >= GUARD);
        nibble_next = active_reg[idx_reg*SEG_DIGIT_W +: SEG_DIGIT_W];
        blank_next  = (LZ_BLANK != 0) ? blank_mask[idx_reg] : 1'b0;
        an_next     = (display_en && guard_done) ? an_sel : AN_OFF[DIGITS-1:0];
        dp_next     = display_en ? ~active_dp_reg[idx_reg] : 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            digit_nibble <= '0;
            digit_blank  <= 1'b1;
            an_n         <= AN_OFF[DIGITS-1:0];
            dp_n         <= 1'b1;
        end else begin
            digit_nibble <= nibble_next;
            digit_blank  <= blank_next;
            an_n         <= an_next;
            dp_n         <= dp_next;
        end
    end

endmodule
